multi_key_decoder: RTL and testbench

Parametrised multi-channel successor to the single-key decoder. Watches the keyboard scan-code stream (keyCode/make/brakee) and tracks NUM_KEYS configurable keys in parallel. Each key gets held, rising-edge, toggle-latch and typematic auto-repeat outputs. Sits between the PS/2 keyboard interface and game-control logic (player movement, fire, pause).

---
 rtl/key_decoder_pkg.sv | 30 +++
 rtl/multi_key_decoder_if.sv | 13 +
 rtl/key_channel.sv | 103 ++++++++++
 rtl/multi_key_decoder.sv | 44 ++++
 tb/tb_multi_key_decoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_decoder_pkg.sv
// Shared types and scan-code constants for the multi-channel key decoder.
// Imported by the channel, the top level and the scan-stream interface.
package key_decoder_pkg;

  typedef logic [8:0] keycode_t;

  // Extended codes carry the E0 prefix in bit 8.
  localparam keycode_t KEY_SPACE = 9'h029;
  localparam keycode_t KEY_LEFT  = 9'h16B;
  localparam keycode_t KEY_RIGHT = 9'h174;
  localparam keycode_t KEY_UP    = 9'h175;
  localparam keycode_t KEY_DOWN  = 9'h172;
  localparam keycode_t KEY_P     = 9'h04D;
  localparam keycode_t KEY_ENTER = 9'h05A;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } repeat_state_t;

  // Counter wide enough to hold the larger of the two reload values.
  function automatic int unsigned repeat_cnt_width(input int unsigned delay,
                                                   input int unsigned rate);
    int unsigned max_v;
    max_v = (delay > rate) ? delay : rate;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/multi_key_decoder_if.sv
// Scan-code stream from the PS/2 keyboard front end: code plus make/break strobes.
// The keyboard side drives through master; decoders listen through slave.
interface multi_key_decoder_if;
  import key_decoder_pkg::*;

  keycode_t keyCode;
  logic     make;
  logic     brakee;

  modport master (output keyCode, output make, output brakee);
  modport slave  (input keyCode, input make, input brakee);

endinterface

// File: rtl/key_channel.sv
// One tracked key: code compare, held flag, press edge, toggle latch and
// typematic repeat FSM. Instantiated once per channel by multi_key_decoder.
module key_channel
  import key_decoder_pkg::*;
#(
  parameter keycode_t    KEY_CODE     = KEY_SPACE,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic     clk,
  input  logic     resetN,
  input  keycode_t key_code_i,
  input  logic     make_i,
  input  logic     brake_i,
  output logic     pressed_o,
  output logic     rise_o,
  output logic     latch_o,
  output logic     repeat_o
);

  localparam int unsigned CntW = repeat_cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CntW-1:0] DelayLoad = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLoad  = CntW'(REPEAT_RATE - 1);

  logic            match;
  logic            pressed_q, pressed_d;
  logic            pressed_dly_q;
  logic            latch_q, latch_d;
  logic            rise;
  logic            fsm_pulse;
  repeat_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign match = (key_code_i == KEY_CODE);
  assign rise  = pressed_q & ~pressed_dly_q;

  // Break wins over a simultaneous make; a repeated make while held is a no-op.
  always_comb begin
    pressed_d = pressed_q;
    if (match && brake_i) begin
      pressed_d = 1'b0;
    end else if (match && make_i) begin
      pressed_d = 1'b1;
    end
  end

  assign latch_d = latch_q ^ rise;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_pulse = 1'b0;
    if (!pressed_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = DELAY;
            cnt_d   = DelayLoad;
          end
        end
        DELAY, REPEAT: begin
          if (cnt_q == '0) begin
            fsm_pulse = 1'b1;
            state_d   = REPEAT;
            cnt_d     = RateLoad;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pressed_q     <= 1'b0;
      pressed_dly_q <= 1'b0;
      latch_q       <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
    end else begin
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_q;
      latch_q       <= latch_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pressed_o = pressed_q;
  assign rise_o    = rise;
  assign latch_o   = latch_q;
  assign repeat_o  = rise | (REPEAT_EN & fsm_pulse);

endmodule

// File: rtl/multi_key_decoder.sv
// Tracks NUM_KEYS configurable keys from the scan-code stream in parallel,
// giving held, press-edge, toggle and auto-repeat outputs per key.
module multi_key_decoder
  import key_decoder_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  // Entry 0 is the rightmost element: channels 0..3 are left, right, space, P.
  parameter logic [NUM_KEYS-1:0][8:0] KEY_CODES = {KEY_P, KEY_SPACE, KEY_RIGHT, KEY_LEFT},
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic                clk,
  input  logic                resetN,
  multi_key_decoder_if.slave  scan,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyRisingEdgePulse,
  output logic [NUM_KEYS-1:0] keyLatch,
  output logic [NUM_KEYS-1:0] keyRepeatPulse,
  output logic                anyKeyPressed
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_channel #(
      .KEY_CODE     (KEY_CODES[i]),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk        (clk),
      .resetN     (resetN),
      .key_code_i (scan.keyCode),
      .make_i     (scan.make),
      .brake_i    (scan.brakee),
      .pressed_o  (keyIsPressed[i]),
      .rise_o     (keyRisingEdgePulse[i]),
      .latch_o    (keyLatch[i]),
      .repeat_o   (keyRepeatPulse[i])
    );
  end

  assign anyKeyPressed = |keyIsPressed;

endmodule

// File: tb/tb_multi_key_decoder.sv
// Bench for multi_key_decoder: directed scenarios plus random scan traffic,
// checked every cycle against a press-age reference model.
module tb_multi_key_decoder;
  import key_decoder_pkg::*;

  localparam int unsigned NK = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 4;
  localparam logic [NK-1:0][8:0] CODES_A = {KEY_P, KEY_SPACE, KEY_RIGHT, KEY_LEFT};
  localparam logic [NK-1:0][8:0] CODES_B = {KEY_P, KEY_SPACE, KEY_SPACE, KEY_LEFT};

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  multi_key_decoder_if kif ();

  logic [NK-1:0] a_pr, a_ri, a_la, a_rp;
  logic [NK-1:0] b_pr, b_ri, b_la, b_rp;
  logic          a_any, b_any;

  multi_key_decoder #(
    .NUM_KEYS (NK), .KEY_CODES (CODES_A), .REPEAT_EN (1'b1),
    .REPEAT_DELAY (RD), .REPEAT_RATE (RR)
  ) dut_a (
    .clk (clk), .resetN (resetN), .scan (kif),
    .keyIsPressed (a_pr), .keyRisingEdgePulse (a_ri), .keyLatch (a_la),
    .keyRepeatPulse (a_rp), .anyKeyPressed (a_any)
  );

  multi_key_decoder #(
    .NUM_KEYS (NK), .KEY_CODES (CODES_B), .REPEAT_EN (1'b1),
    .REPEAT_DELAY (RD), .REPEAT_RATE (RR)
  ) dut_b (
    .clk (clk), .resetN (resetN), .scan (kif),
    .keyIsPressed (b_pr), .keyRisingEdgePulse (b_ri), .keyLatch (b_la),
    .keyRepeatPulse (b_rp), .anyKeyPressed (b_any)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: held flag, previous held flag, latch, cycles since press.
  keycode_t    codes  [2][NK];
  bit          m_pr   [2][NK];
  bit          m_prev [2][NK];
  bit          m_la   [2][NK];
  int unsigned m_age  [2][NK];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NK; k++) begin
        m_pr[d][k] = 0; m_prev[d][k] = 0; m_la[d][k] = 0; m_age[d][k] = 0;
      end
    end
  endtask

  task automatic model_clock(input keycode_t code, input bit mk, input bit br);
    bit match, np, rise;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NK; k++) begin
        match = (code == codes[d][k]);
        np    = (match && br) ? 1'b0 : (match && mk) ? 1'b1 : m_pr[d][k];
        rise  = m_pr[d][k] && !m_prev[d][k];
        if (rise) m_la[d][k] = !m_la[d][k];
        if (np && !m_pr[d][k]) m_age[d][k] = 0;
        else if (np) m_age[d][k] = m_age[d][k] + 1;
        m_prev[d][k] = m_pr[d][k];
        m_pr[d][k]   = np;
      end
    end
  endtask

  // sel: 0 held, 1 press edge, 2 latch, 3 repeat pulse
  function automatic logic [NK-1:0] exp_vec(input int d, input int sel);
    logic [NK-1:0] v;
    int unsigned   a;
    v = '0;
    for (int k = 0; k < NK; k++) begin
      a = m_age[d][k];
      case (sel)
        0: v[k] = m_pr[d][k];
        1: v[k] = m_pr[d][k] && !m_prev[d][k];
        2: v[k] = m_la[d][k];
        default: v[k] = m_pr[d][k] && (a == 0 || (a >= RD && (a - RD) % RR == 0));
      endcase
    end
    return v;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".a_pressed"}, 64'(a_pr), 64'(exp_vec(0, 0)));
    check_eq({tag, ".a_rise"},    64'(a_ri), 64'(exp_vec(0, 1)));
    check_eq({tag, ".a_latch"},   64'(a_la), 64'(exp_vec(0, 2)));
    check_eq({tag, ".a_repeat"},  64'(a_rp), 64'(exp_vec(0, 3)));
    check_eq({tag, ".a_any"},     64'(a_any), 64'(|exp_vec(0, 0)));
    check_eq({tag, ".b_pressed"}, 64'(b_pr), 64'(exp_vec(1, 0)));
    check_eq({tag, ".b_rise"},    64'(b_ri), 64'(exp_vec(1, 1)));
    check_eq({tag, ".b_latch"},   64'(b_la), 64'(exp_vec(1, 2)));
    check_eq({tag, ".b_repeat"},  64'(b_rp), 64'(exp_vec(1, 3)));
    check_eq({tag, ".b_any"},     64'(b_any), 64'(|exp_vec(1, 0)));
  endtask

  // Called at a negedge: present inputs for one cycle, then check the outputs.
  task automatic step(input string tag, input keycode_t code, input bit mk, input bit br);
    kif.keyCode = code;
    kif.make    = mk;
    kif.brakee  = br;
    @(posedge clk);
    model_clock(code, mk, br);
    @(negedge clk);
    kif.make   = 1'b0;
    kif.brakee = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 9'h000, 1'b0, 1'b0);
  endtask

  logic [63:0] pulse_mask;
  logic [NK-1:0] rp_or;
  keycode_t      rcode;
  logic [NK-1:0][8:0] ca, cb;

  initial begin
    ca = CODES_A;
    cb = CODES_B;
    for (int k = 0; k < NK; k++) begin
      codes[0][k] = ca[k];
      codes[1][k] = cb[k];
    end
    kif.keyCode = '0; kif.make = 1'b0; kif.brakee = 1'b0;
    resetN = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    resetN = 1'b1;

    // Single press of space
    step("single", KEY_SPACE, 1'b1, 1'b0);
    check_eq("single.pressed", 64'(a_pr), 64'h4);
    check_eq("single.repeat",  64'(a_rp), 64'h4);
    check_eq("single.latch_t1", 64'(a_la), 64'h0);
    idle("single", 1);
    check_eq("single.latch_t2", 64'(a_la), 64'h4);
    check_eq("single.no_pulse", 64'(a_rp), 64'h0);
    step("single", KEY_SPACE, 1'b0, 1'b1);
    idle("single", 2);

    // Auto-repeat on left: hold, break on the 31st step
    pulse_mask = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 1)       step("repeat", KEY_LEFT, 1'b1, 1'b0);
      else if (k == 31) step("repeat", KEY_LEFT, 1'b0, 1'b1);
      else              idle("repeat", 1);
      if (a_rp[0]) pulse_mask[k] = 1'b1;
    end
    check_eq("repeat.times", pulse_mask,
             (64'd1 << 1) | (64'd1 << 11) | (64'd1 << 15) | (64'd1 << 19) |
             (64'd1 << 23) | (64'd1 << 27));

    // Latch toggling on right
    for (int n = 0; n < 3; n++) begin
      step("latch", KEY_RIGHT, 1'b1, 1'b0);
      idle("latch", 1);
      check_eq("latch.seq", 64'(a_la[1]), (n % 2 == 0) ? 64'd1 : 64'd0);
      step("latch", KEY_RIGHT, 1'b0, 1'b1);
      idle("latch", 1);
    end
    step("latch", KEY_RIGHT, 1'b1, 1'b0);
    idle("latch", 1);
    step("latch", KEY_RIGHT, 1'b1, 1'b0);
    step("latch", KEY_RIGHT, 1'b1, 1'b0);
    idle("latch", 2);
    check_eq("latch.typematic", 64'(a_la[1]), 64'd0);
    step("latch", KEY_RIGHT, 1'b0, 1'b1);
    idle("latch", 2);

    // Simultaneous make and break on P, idle and while held
    step("simul", KEY_P, 1'b1, 1'b1);
    check_eq("simul.idle_pr", 64'(a_pr[3]), 64'd0);
    check_eq("simul.idle_rp", 64'(a_rp[3]), 64'd0);
    step("simul", KEY_P, 1'b1, 1'b0);
    idle("simul", 2);
    step("simul", KEY_P, 1'b1, 1'b1);
    check_eq("simul.held_pr", 64'(a_pr[3]), 64'd0);
    idle("simul", 2);

    // Overlapping presses keep anyKeyPressed up
    step("multi", KEY_LEFT, 1'b1, 1'b0);
    step("multi", KEY_SPACE, 1'b1, 1'b0);
    step("multi", KEY_LEFT, 1'b0, 1'b1);
    check_eq("multi.any_held", 64'(a_any), 64'd1);
    idle("multi", 3);
    check_eq("multi.any_still", 64'(a_any), 64'd1);
    step("multi", KEY_SPACE, 1'b0, 1'b1);
    check_eq("multi.any_clear", 64'(a_any), 64'd0);
    idle("multi", 2);

    // Duplicate codes respond together
    step("dup", KEY_SPACE, 1'b1, 1'b0);
    check_eq("dup.rise", 64'(b_ri), 64'h6);
    step("dup", KEY_SPACE, 1'b0, 1'b1);
    idle("dup", 2);

    // Reset in the middle of repeating on space
    step("midrst", KEY_SPACE, 1'b1, 1'b0);
    idle("midrst", 12);
    resetN = 1'b0;
    #1;
    check_eq("midrst.a_pr", 64'(a_pr), 64'h0);
    check_eq("midrst.a_la", 64'(a_la), 64'h0);
    check_eq("midrst.a_rp", 64'(a_rp), 64'h0);
    check_eq("midrst.b_pr", 64'(b_pr), 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    rp_or = '0;
    for (int i = 0; i < 15; i++) begin
      idle("postrst", 1);
      rp_or = rp_or | a_rp | a_pr;
    end
    check_eq("postrst.quiet", 64'(rp_or), 64'h0);
    step("postrst", KEY_SPACE, 1'b1, 1'b0);
    check_eq("postrst.new_make", 64'(a_rp), 64'h4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: rcode = KEY_LEFT;
        1: rcode = KEY_RIGHT;
        2: rcode = KEY_SPACE;
        3: rcode = KEY_P;
        4: rcode = KEY_UP;
        default: rcode = keycode_t'($urandom_range(0, 511));
      endcase
      step("rand", rcode, ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
